datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  in  1  rising-edge clock, shared with datapath
- rst_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in WAIT
- instr  in  16  instruction word; captured into IR when s accepted
- w  out  1  ready; 1 only in state WAIT
- illegal  out  1  one-cycle pulse when an undefined instruction is decoded
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- vsel  out  1  writeback select: 1 = datapath_in (immediate), 0 = C
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status (Z) register
- asel  out  1  ALU A operand: 0 = A register, 1 = zero
- bsel  out  1  ALU B operand: 0 = shifted B; driven 0 permanently
- shift  out  2  shifter control
- ALUop  out  2  ALU operation: 00 add, 01 subtract, 10 and, 11 not-B
- sximm8  out  16  IR[7:0] sign-extended; drives datapath_in
REQ-002 SHALL operate on one clock, clk; reset is rst_n, asynchronous, active-low.

Function
REQ-003 IR field layout SHALL be: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0], imm8 IR[7:0].
REQ-004 Decoded instructions SHALL be:
- 110/10: MOV Rn,#imm8
- 110/00: MOV Rd,Rm{,sh}
- 101/00: ADD Rd,Rn,Rm{,sh}
- 101/01: CMP Rn,Rm{,sh}
- 101/10: AND Rd,Rn,Rm{,sh}
- 101/11: MVN Rd,Rm{,sh}
- all other encodings: illegal.
REQ-005 States SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG, with Moore outputs decoded from state and IR only.
REQ-006 In WAIT with s=1 at a rising edge, IR SHALL load instr and the FSM SHALL go to DECODE; s in any other state SHALL be ignored and IR held.
REQ-007 DECODE transitions SHALL be:
- MOV imm -> WRITE_IMM
- ADD/CMP/AND -> GET_A
- MOV reg/MVN -> GET_B
- illegal -> WAIT, with illegal=1 during the DECODE cycle.
REQ-008 Sequencing SHALL be GET_A -> GET_B -> EXEC; WRITE_IMM -> WAIT; WRITE_REG -> WAIT; EXEC -> WAIT for CMP and EXEC -> WRITE_REG otherwise.
REQ-009 Per-state outputs SHALL be (every output not listed is 0):
- WRITE_IMM: write=1, vsel=1, writenum=Rn
- GET_A: loada=1, readnum=Rn
- GET_B: loadb=1, readnum=Rm
- EXEC: loadc=1, shift=sh, ALUop=op; asel=1 for MOV reg, else 0; loads=1 only for CMP
- WRITE_REG: write=1, vsel=0, writenum=Rd.
REQ-010 readnum and writenum SHALL be 0 in states where they are not listed.
REQ-011 MOV reg SHALL use ALUop=00 with asel=1 (0 + shifted Rm).
REQ-012 Latency from the accept edge E0: MOV imm SHALL write the register at E2; MOV reg/MVN SHALL write at E4; ADD/AND SHALL write at E5; CMP SHALL load status at E4. w SHALL return to 1 after the final edge.
REQ-013 sximm8 SHALL equal {8{IR[7]}, IR[7:0]} continuously.

Reset
REQ-014 rst_n=0 SHALL immediately force state WAIT and IR=0x0000, at any time including mid-instruction.
REQ-015 During reset: w=1, sximm8=0, and all other outputs 0.
REQ-016 An instruction interrupted by reset SHALL produce no further write, loadc or loads.
REQ-017 After rst_n rises, the first accepted s SHALL start a normal instruction.

Verification
REQ-018 Bench SHALL cover:
- instr=0xD007, s pulse -> at E1 write=1, vsel=1, writenum=0, sximm8=0x0007; w=1 after E2
- instr=0xD3FF -> sximm8=0xFFFF, writenum=3
- instr=0xA148 -> GET_A readnum=1; GET_B readnum=0; EXEC shift=01, ALUop=00, loadc=1, loads=0; WRITE_REG writenum=2, vsel=0; w=1 after E5
- instr=0xA900 -> EXEC ALUop=01, loads=1; no write asserted; w=1 after E4
- instr=0xB883 -> GET_B readnum=3, EXEC ALUop=11, WRITE_REG writenum=4; s=1 held throughout has no effect and IR unchanged
- instr=0x0000 -> illegal=1 for one cycle, back to WAIT with no loads or writes; rst_n=0 during EXEC of 0xA148 -> all outputs 0 and w=1 at once, and no write afterwards

Source files
------------

// File: rtl/datapath_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : datapath_ctrl
// Description : Multi-cycle Moore controller for a simple register-file
//               datapath. Captures an instruction into IR on start, decodes
//               it and sequences register reads, ALU execution and
//               writeback. Flags undefined encodings with a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8
);

    localparam logic [2:0] c_WAIT      = 3'd0;
    localparam logic [2:0] c_DECODE    = 3'd1;
    localparam logic [2:0] c_WRITE_IMM = 3'd2;
    localparam logic [2:0] c_GET_A     = 3'd3;
    localparam logic [2:0] c_GET_B     = 3'd4;
    localparam logic [2:0] c_EXEC      = 3'd5;
    localparam logic [2:0] c_WRITE_REG = 3'd6;

    localparam logic [2:0] c_OPC_MOV = 3'b110;
    localparam logic [2:0] c_OPC_ALU = 3'b101;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_ir;

    // IR field views
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    // Instruction class decode
    logic w_is_mov_imm;
    logic w_is_mov_reg;
    logic w_is_alu;
    logic w_is_cmp;
    logic w_is_mvn;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_mov_imm = (w_opcode == c_OPC_MOV) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == c_OPC_MOV) && (w_op == 2'b00);
    assign w_is_alu     = (w_opcode == c_OPC_ALU);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn     = w_is_alu && (w_op == 2'b11);

    // Immediate is always presented, sign-extended, from the held IR
    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IR captures only on an accepted start, so s is ignored while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= 16'h0000;
        end else if ((r_state == c_WAIT) && s) begin
            r_ir <= instr;
        end
    end

    // Next-state sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT: begin
                if (s) w_state_nxt = c_DECODE;
            end
            c_DECODE: begin
                if (w_is_mov_imm)
                    w_state_nxt = c_WRITE_IMM;
                else if (w_is_mov_reg || w_is_mvn)
                    w_state_nxt = c_GET_B;
                else if (w_is_alu)
                    w_state_nxt = c_GET_A;
                else
                    w_state_nxt = c_WAIT;
            end
            c_WRITE_IMM: w_state_nxt = c_WAIT;
            c_GET_A:     w_state_nxt = c_GET_B;
            c_GET_B:     w_state_nxt = c_EXEC;
            c_EXEC:      w_state_nxt = w_is_cmp ? c_WAIT : c_WRITE_REG;
            c_WRITE_REG: w_state_nxt = c_WAIT;
            default:     w_state_nxt = c_WAIT;
        endcase
    end

    // Moore outputs from state and IR; everything idles at zero
    always_comb begin
        w        = 1'b0;
        illegal  = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (r_state)
            c_WAIT: begin
                w = 1'b1;
            end
            c_DECODE: begin
                illegal = !(w_is_mov_imm || w_is_mov_reg || w_is_alu);
            end
            c_WRITE_IMM: begin
                write    = 1'b1;
                vsel     = 1'b1;
                writenum = w_rn;
            end
            c_GET_A: begin
                loada   = 1'b1;
                readnum = w_rn;
            end
            c_GET_B: begin
                loadb   = 1'b1;
                readnum = w_rm;
            end
            c_EXEC: begin
                loadc = 1'b1;
                shift = w_sh;
                // MOV reg encodes op=00, so it rides the adder as 0 + shifted Rm
                ALUop = w_op;
                asel  = w_is_mov_reg;
                loads = w_is_cmp;
            end
            c_WRITE_REG: begin
                write    = 1'b1;
                writenum = w_rd;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_ctrl
// Description : Directed self-checking bench for datapath_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_ctrl;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;

    int n_cmp;
    int n_bad;

    datapath_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .illegal  (illegal),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every control output, bsel included
    logic [19:0] w_outs;
    assign w_outs = {w, illegal, readnum, writenum, write, vsel, loada, loadb,
                     loadc, loads, asel, bsel, shift, ALUop};

    function automatic logic [19:0] mk(
        input logic       e_w,  input logic       e_ill,
        input logic [2:0] e_rn, input logic [2:0] e_wn,
        input logic       e_wr, input logic       e_vs,
        input logic       e_la, input logic       e_lb,
        input logic       e_lc, input logic       e_ls,
        input logic       e_as, input logic [1:0] e_sh,
        input logic [1:0] e_op);
        return {e_w, e_ill, e_rn, e_wn, e_wr, e_vs, e_la, e_lb,
                e_lc, e_ls, e_as, 1'b0, e_sh, e_op};
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp_o,
                       input logic [15:0] exp_x);
        n_cmp++;
        assert ({w_outs, sximm8} === {exp_o, exp_x})
        else begin
            n_bad++;
            $error("FAIL %s outs=%h sximm8=%h expected outs=%h sximm8=%h",
                   tag, w_outs, sximm8, exp_o, exp_x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present instr with s for one edge (E0); returns 1ns after E0
    task automatic start(input logic [15:0] iw);
        instr = iw;
        s     = 1'b1;
        tick();
        s     = 1'b0;
    endtask

    logic [19:0] c_idle;
    logic [19:0] c_busy0;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        c_idle  = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00);
        c_busy0 = mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00);
        rst_n = 1'b0;
        s     = 1'b0;
        instr = 16'h0000;
        #2;
        chk("reset_state", c_idle, 16'h0000);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("idle_after_reset", c_idle, 16'h0000);

        // MOV R0,#7
        start(16'hD007);
        chk("movimm_decode", c_busy0, 16'h0007);
        tick();
        chk("movimm_write", mk(0,0,0,0,1,1,0,0,0,0,0,2'b00,2'b00), 16'h0007);
        tick();
        chk("movimm_done", c_idle, 16'h0007);

        // MOV R3,#-1
        start(16'hD3FF);
        tick();
        chk("movimm_neg_write", mk(0,0,0,3,1,1,0,0,0,0,0,2'b00,2'b00), 16'hFFFF);
        tick();
        chk("movimm_neg_done", c_idle, 16'hFFFF);

        // ADD R2,R1,R0,LSL#1
        start(16'hA148);
        tick();
        chk("add_get_a", mk(0,0,1,0,0,0,1,0,0,0,0,2'b00,2'b00), 16'h0048);
        tick();
        chk("add_get_b", mk(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00), 16'h0048);
        tick();
        chk("add_exec", mk(0,0,0,0,0,0,0,0,1,0,0,2'b01,2'b00), 16'h0048);
        tick();
        chk("add_write", mk(0,0,0,2,1,0,0,0,0,0,0,2'b00,2'b00), 16'h0048);
        tick();
        chk("add_done", c_idle, 16'h0048);

        // CMP R1,R0
        start(16'hA900);
        tick();
        chk("cmp_get_a", mk(0,0,1,0,0,0,1,0,0,0,0,2'b00,2'b00), 16'h0000);
        tick();
        chk("cmp_get_b", mk(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00), 16'h0000);
        tick();
        chk("cmp_exec", mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b01), 16'h0000);
        tick();
        chk("cmp_done_no_write", c_idle, 16'h0000);

        // MVN R4,R3 with s held high and instr changing underneath
        start(16'hB883);
        s     = 1'b1;
        instr = 16'hD007;
        tick();
        chk("mvn_get_b", mk(0,0,3,0,0,0,0,1,0,0,0,2'b00,2'b00), 16'hFF83);
        tick();
        chk("mvn_exec", mk(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b11), 16'hFF83);
        tick();
        chk("mvn_write", mk(0,0,0,4,1,0,0,0,0,0,0,2'b00,2'b00), 16'hFF83);
        tick();
        s = 1'b0;
        chk("mvn_done_ir_held", c_idle, 16'hFF83);

        // MOV R?,R2,LSL#1 (MOV reg uses zero A operand)
        start(16'hC04A);
        tick();
        chk("movreg_get_b", mk(0,0,2,0,0,0,0,1,0,0,0,2'b00,2'b00), 16'h004A);
        tick();
        chk("movreg_exec", mk(0,0,0,0,0,0,0,0,1,0,1,2'b01,2'b00), 16'h004A);
        tick();
        chk("movreg_write", mk(0,0,0,2,1,0,0,0,0,0,0,2'b00,2'b00), 16'h004A);
        tick();
        chk("movreg_done", c_idle, 16'h004A);

        // Illegal encoding
        start(16'h0000);
        chk("illegal_pulse", mk(0,1,0,0,0,0,0,0,0,0,0,2'b00,2'b00), 16'h0000);
        tick();
        chk("illegal_back_wait", c_idle, 16'h0000);

        // Reset asserted during EXEC of ADD
        start(16'hA148);
        tick();
        tick();
        tick();
        chk("pre_reset_exec", mk(0,0,0,0,0,0,0,0,1,0,0,2'b01,2'b00), 16'h0048);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_mid", c_idle, 16'h0000);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_quiet", c_idle, 16'h0000);
        end

        // First start after reset runs normally
        start(16'hD007);
        tick();
        chk("post_reset_movimm", mk(0,0,0,0,1,1,0,0,0,0,0,2'b00,2'b00), 16'h0007);
        tick();
        chk("post_reset_done", c_idle, 16'h0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
